// File: rtl/memory_dbus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_dbus_ctrl_pkg
// Purpose  : Shared types for the data-bus controller and its alignment unit.
// Revision : 1.0 - initial release
// ============================================================================
package memory_dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    MSIZE_BYTE = 2'd0,
    MSIZE_HALF = 2'd1,
    MSIZE_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } dbus_state_t;

  // Size code 3 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MSIZE_BYTE: is_misaligned = 1'b0;
      MSIZE_HALF: is_misaligned = off[0];
      default:    is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_dbus_ctrl_align.sv
`default_nettype none
// ============================================================================
// Module   : memory_align
// Purpose  : Store strobe/data lane replication and load lane extraction.
// Revision : 1.0 - initial release
// ============================================================================
module memory_align
  import memory_dbus_ctrl_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_strobe,
  output logic [31:0] o_st_data,
  input  logic [1:0]  i_ld_off,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_sign,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_strobe = 4'b1111;
    o_st_data   = i_st_wdata;
    case (i_st_size)
      MSIZE_BYTE: begin
        o_st_strobe = 4'b0001 << i_st_off;
        o_st_data   = {4{i_st_wdata[7:0]}};
      end
      MSIZE_HALF: begin
        o_st_strobe = 4'b0011 << i_st_off;
        o_st_data   = {2{i_st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign w_shift = i_ld_raw >> {i_ld_off, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_shift[15:0];

  always_comb begin
    o_ld_data = i_ld_raw;
    case (i_ld_size)
      MSIZE_BYTE: o_ld_data = {{24{i_ld_sign & w_byte[7]}}, w_byte};
      MSIZE_HALF: o_ld_data = {{16{i_ld_sign & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : memory_dbus_ctrl
// Purpose  : Load/store unit bridging the memory stage to a split addr/data bus.
// Revision : 1.0 - initial release
// ============================================================================
module memory_dbus_ctrl
  import memory_dbus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_addr,
  input  logic        in_write,
  input  logic [1:0]  in_size,
  input  logic        in_sign,
  input  logic [31:0] in_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data
);

  dbus_state_t r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [1:0]  r_size;
  logic        r_sign, r_write, r_exc_adel, r_exc_ades;
  logic [3:0]  r_strobe;

  logic        w_accept, w_take, w_mis;
  logic [3:0]  w_st_strobe;
  logic [31:0] w_st_data, w_ld_data;
  dbus_req_t   w_req;
  dbus_resp_t  w_resp;

  assign w_resp   = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};
  assign w_mis    = is_misaligned(in_size, in_addr[1:0]);
  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_take   = ((r_state == ST_REQ) && w_resp.addr_ok && w_resp.data_ok) ||
                    ((r_state == ST_WAIT) && w_resp.data_ok);

  memory_align u_align (
    .i_st_off    (in_addr[1:0]),
    .i_st_size   (in_size),
    .i_st_wdata  (in_wdata),
    .o_st_strobe (w_st_strobe),
    .o_st_data   (w_st_data),
    .i_ld_off    (r_addr[1:0]),
    .i_ld_size   (r_size),
    .i_ld_sign   (r_sign),
    .i_ld_raw    (w_resp.data),
    .o_ld_data   (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = w_mis ? ST_RESP : ST_REQ;
      ST_REQ:  if (w_resp.addr_ok) w_next = w_resp.data_ok ? ST_RESP : ST_WAIT;
      ST_WAIT: if (w_resp.data_ok) w_next = ST_RESP;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_RESP);
    w_req.valid  = (r_state == ST_REQ);
    w_req.addr   = r_addr;
    w_req.strobe = r_strobe;
    w_req.data   = r_wdata;
    rdata        = done ? r_rdata : 32'd0;
    exc_adel     = done & r_exc_adel;
    exc_ades     = done & r_exc_ades;
  end

  assign dreq_valid  = w_req.valid;
  assign dreq_addr   = w_req.addr;
  assign dreq_strobe = w_req.strobe;
  assign dreq_data   = w_req.data;

  // Request fields are latched once at accept so the bus sees them stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_sign     <= 1'b0;
      r_write    <= 1'b0;
      r_strobe   <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_exc_adel <= 1'b0;
      r_exc_ades <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= in_addr;
        r_size     <= in_size;
        r_sign     <= in_sign;
        r_write    <= in_write;
        r_strobe   <= in_write ? w_st_strobe : 4'b0000;
        r_wdata    <= in_write ? w_st_data : 32'd0;
        r_rdata    <= '0;
        r_exc_adel <= w_mis & ~in_write;
        r_exc_ades <= w_mis & in_write;
      end
      if (w_take) r_rdata <= r_write ? 32'd0 : w_ld_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_dbus_ctrl
// Purpose  : Directed vector bench for memory_dbus_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_dbus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_write, in_sign;
  logic [31:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic        busy, done, exc_adel, exc_ades, dreq_valid;
  logic [31:0] rdata, dreq_addr, dreq_data;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memory_dbus_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_write(in_write),
    .in_size(in_size), .in_sign(in_sign), .in_wdata(in_wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] wdata;
    logic [31:0] resp;
    int          aok;    // REQ cycles before addr_ok
    int          dok;    // cycles from addr_ok to data_ok
    logic        noise;  // drive a stray request while busy
    logic [3:0]  e_strb;
    logic [31:0] e_data;
    logic [31:0] e_rdata;
    logic        e_adel;
    logic        e_ades;
    int          e_done;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int idx);
    int  nreq, ca, exp_nreq;
    bit  got;
    nreq = 0; ca = -1; got = 0;
    exp_nreq = (t.e_adel | t.e_ades) ? 0 : t.aok + 1;
    @(negedge clk);
    chk($sformatf("v%0d idle_busy", idx), {31'd0, busy}, 32'd0);
    in_valid = 1'b1; in_addr = t.addr; in_write = t.wr; in_size = t.size;
    in_sign = t.sign; in_wdata = t.wdata; dresp_data = t.resp;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      in_valid = t.noise;
      in_addr  = t.noise ? 32'h0BAD_0000 : t.addr;
      in_write = 1'b0; in_size = 2'd2;
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      chk($sformatf("v%0d busy c%0d", idx, k), {31'd0, busy}, 32'd1);
      if (done) begin
        got = 1;
        in_valid = 1'b0;
        chk($sformatf("v%0d done_cycle", idx), k, t.e_done);
        chk($sformatf("v%0d rdata", idx), rdata, t.e_rdata);
        chk($sformatf("v%0d adel", idx), {31'd0, exc_adel}, {31'd0, t.e_adel});
        chk($sformatf("v%0d ades", idx), {31'd0, exc_ades}, {31'd0, t.e_ades});
        chk($sformatf("v%0d req_cycles", idx), nreq, exp_nreq);
      end else if (dreq_valid) begin
        chk($sformatf("v%0d dreq_addr c%0d", idx, k), dreq_addr, t.addr);
        chk($sformatf("v%0d dreq_strobe c%0d", idx, k), {28'd0, dreq_strobe}, {28'd0, t.e_strb});
        if (t.wr) chk($sformatf("v%0d dreq_data c%0d", idx, k), dreq_data, t.e_data);
        if (nreq == t.aok) begin
          dresp_addr_ok = 1'b1;
          ca = k;
          if (t.dok == 0) dresp_data_ok = 1'b1;
        end
        nreq++;
      end else if (ca >= 0 && k == ca + t.dok) begin
        dresp_data_ok = 1'b1;
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d timeout actual=no_done required=done", idx);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_write = 1'b0; in_size = '0;
    in_sign = 1'b0; in_wdata = '0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    dresp_data = '0;

    //          addr          wr    sz    sg    wdata         resp          aok dok nz    strb     data          rdata         adel  ades  done
    vecs[0]  = '{32'h1000_0004, 1'b0, 2'd2, 1'b0, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 2};
    vecs[1]  = '{32'h0000_0103, 1'b0, 2'd0, 1'b1, 32'h0,        32'h80FF_FFFF, 0, 0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 2};
    vecs[2]  = '{32'h0000_0103, 1'b0, 2'd0, 1'b0, 32'h0,        32'h80FF_FFFF, 0, 0, 1'b0, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 2};
    vecs[3]  = '{32'h0000_2002, 1'b1, 2'd1, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 3, 0, 1'b0, 4'b1100, 32'h1234_1234, 32'h0,        1'b0, 1'b0, 5};
    vecs[4]  = '{32'h0000_3001, 1'b0, 2'd2, 1'b0, 32'h0,        32'h1111_1111, 0, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1};
    vecs[5]  = '{32'h0000_3003, 1'b1, 2'd1, 1'b0, 32'h0000_5678, 32'h1111_1111, 0, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 1};
    vecs[6]  = '{32'h0000_4000, 1'b0, 2'd2, 1'b0, 32'h0,        32'h1234_5678, 0, 3, 1'b1, 4'b0000, 32'h0,        32'h1234_5678, 1'b0, 1'b0, 5};
    vecs[7]  = '{32'h0000_5001, 1'b1, 2'd0, 1'b0, 32'h0000_00AB, 32'h2222_2222, 0, 1, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0, 1'b0, 3};
    vecs[8]  = '{32'h0000_6002, 1'b0, 2'd1, 1'b1, 32'h0,        32'h8001_7FFF, 0, 0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0, 2};
    vecs[9]  = '{32'h0000_6000, 1'b0, 2'd1, 1'b0, 32'h0,        32'h1234_9ABC, 0, 0, 1'b0, 4'b0000, 32'h0,        32'h0000_9ABC, 1'b0, 1'b0, 2};
    vecs[10] = '{32'h0000_7000, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h3333_3333, 1, 1, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0, 4};
    vecs[11] = '{32'h0000_8000, 1'b0, 2'd3, 1'b1, 32'h0,        32'h55AA_55AA, 0, 0, 1'b0, 4'b0000, 32'h0,        32'h55AA_55AA, 1'b0, 1'b0, 2};
    vecs[12] = '{32'h0000_7002, 1'b1, 2'd2, 1'b0, 32'h1234_5678, 32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 1};
    vecs[13] = '{32'h0000_5003, 1'b1, 2'd0, 1'b0, 32'h1234_56C3, 32'h4444_4444, 2, 2, 1'b0, 4'b1000, 32'hC3C3_C3C3, 32'h0,        1'b0, 1'b0, 6};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst dreq_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst dreq_addr", dreq_addr, 32'd0);
    chk("rst dreq_data", dreq_data, 32'd0);
    chk("rst dreq_strobe", {28'd0, dreq_strobe}, 32'd0);
    chk("rst exc", {30'd0, exc_adel, exc_ades}, 32'd0);

    for (int i = 0; i < 14; i++) run(vecs[i], i);

    // Reset while waiting for data: transfer is dropped with no done pulse.
    @(negedge clk);
    chk("rw idle_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b1; in_addr = 32'h0000_9004; in_write = 1'b0; in_size = 2'd2;
    dresp_data = 32'h7777_7777;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw req_valid", {31'd0, dreq_valid}, 32'd1);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    chk("rw wait_busy", {31'd0, busy}, 32'd1);
    chk("rw wait_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw busy", {31'd0, busy}, 32'd0);
    chk("rw done", {31'd0, done}, 32'd0);
    chk("rw dreq_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rw dreq_addr", dreq_addr, 32'd0);
    chk("rw rdata", rdata, 32'd0);
    dresp_data_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rw no_done c%0d", k), {31'd0, done}, 32'd0);
      chk($sformatf("rw stay_idle c%0d", k), {31'd0, busy}, 32'd0);
    end
    dresp_data_ok = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_dbus_ctrl.md
MEMORY_DBUS_CTRL -- requirements
Module: memory_dbus_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port: in_valid  in  1  access request from the execute/memory stage.
REQ-004 SHALL have port: in_addr  in  32  byte address (the ALU result).
REQ-005 SHALL have port: in_write  in  1  1 = store, 0 = load.
REQ-006 SHALL have port: in_size  in  2  access size: 0 byte, 1 half, 2 word; 3 is treated as word.
REQ-007 SHALL have port: in_sign  in  1  sign-extend load data (LB/LH); 0 means zero-extend.
REQ-008 SHALL have port: in_wdata  in  32  store data, right-aligned.
REQ-009 SHALL have port: busy  out  1  high while a request is held; in_valid is ignored while high.
REQ-010 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: rdata  out  32  extended load result, valid while done=1.
REQ-012 SHALL have port: exc_adel / exc_ades  out  1 each  misaligned load / store flag, valid while done=1.
REQ-013 SHALL have port: dreq_valid  out  1  bus request.
REQ-014 SHALL have ports: dreq_addr  out  32, dreq_strobe  out  4, dreq_data  out  32; together these form the bus request.
REQ-015 SHALL have ports: dresp_addr_ok  in  1, dresp_data_ok  in  1, dresp_data  in  32; together these form the bus response.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-017 IDLE with in_valid=1 SHALL register addr, size, sign, write and the aligned data/strobe, and SHALL set busy=1 on the next cycle.
REQ-018 Misalignment SHALL be detected as: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-019 A misaligned request SHALL go IDLE->RESP with the matching exc flag set and no bus access (dreq_valid stays 0).
REQ-020 An aligned request SHALL go IDLE->REQ.
REQ-021 In REQ, dreq_valid=1; all dreq_* SHALL be held stable until dresp_addr_ok=1.
REQ-022 Transitions out of REQ SHALL be:
  - addr_ok=1 and data_ok=1 in the same cycle -> RESP;
  - addr_ok=1 only -> WAIT.
REQ-023 In WAIT, dreq_valid=0; data_ok=1 SHALL move the FSM to RESP.
REQ-024 RESP SHALL last exactly one cycle: done=1, busy=1, registered rdata/exc driven; then IDLE.
REQ-025 Minimum latency (aligned access, addr_ok and data_ok both in the first REQ cycle) SHALL be: accept at cycle 0, dreq_valid in cycle 1, done in cycle 2.
REQ-026 Misaligned latency SHALL be: done in cycle 1.
REQ-027 A new request SHALL be accepted in the cycle after RESP at the earliest.
REQ-028 Store strobe SHALL be:
  - byte: 4'b0001<<addr[1:0];
  - half: 4'b0011<<addr[1:0];
  - word: 4'b1111.
REQ-029 Store data SHALL be: byte replicated x4, half replicated x2, word unchanged.
REQ-030 For loads, dreq_strobe SHALL be 0 and dreq_data don't-care.
REQ-031 dreq_addr SHALL equal in_addr unmodified.
REQ-032 Load data SHALL be extracted from dresp_data by addr[1:0] (byte lane or half lane) and extended per in_sign; for a word load, rdata=dresp_data.
REQ-033 For stores, rdata SHALL be 0.
REQ-034 data_ok in IDLE/RESP and addr_ok outside REQ SHALL be ignored.

Reset
REQ-035 On reset=1 at a clock edge the following SHALL hold:
  - FSM -> IDLE;
  - busy, done, dreq_valid, exc_adel, exc_ades = 0;
  - rdata, dreq_addr, dreq_data = 0;
  - dreq_strobe = 0.
REQ-036 Reset mid-transfer SHALL abandon the transfer, with no done pulse; the bus is reset by the same signal.

Structure
REQ-037 A shared package SHALL hold:
  - mem_size_t (MSIZE_BYTE/HALF/WORD);
  - dbus_req_t and dbus_resp_t structs;
  - the FSM state enum.
REQ-038 One combinational sub-module, memory_align, SHALL hold strobe/data replication and load extraction/extension.

Verification
REQ-039 Word load at 0x1000_0004, with addr_ok and data_ok in the first REQ cycle and dresp_data=0xDEAD_BEEF -> done in cycle 2, rdata=0xDEAD_BEEF.
REQ-040 LB with sign=1 at 0x...03, dresp_data=0x80FF_FFFF -> rdata=0xFFFF_FF80; the same access with sign=0 -> rdata=0x0000_0080.
REQ-041 SH at 0x...02 with wdata=0x0000_1234 -> dreq_strobe=4'b1100, dreq_data=0x1234_1234; addr_ok held off 3 cycles -> request held stable throughout, done 1 cycle after data_ok.
REQ-042 LW at 0x...01 -> exc_adel=1 with done in cycle 1 and dreq_valid never 1; SH at 0x...03 -> exc_ades=1.
REQ-043 addr_ok at cycle 1, data_ok at cycle 4 -> WAIT in cycles 2-4, done in cycle 5; a second in_valid during busy is ignored.
REQ-044 Reset asserted while in WAIT -> next cycle IDLE, all outputs 0, no done pulse.
